vga_pattern_engine: RTL and testbench

Parametrised VGA test-pattern generator, the next generation of the single-mode `vga_generator` behind the TinyTapeout top wrapper. It owns horizontal/vertical timing and selects among six patterns, including two animated ones driven by a frame counter. Mode changes are latched only at the frame boundary, so the picture never tears. Colour depth, timing and pattern geometry are parameters; the top wrapper packs the outputs onto `uo_out` in TinyVGA Pmod order.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_timing.sv | 51 +++++
 rtl/vga_pattern_engine.sv | 155 +++++++++++++++
 tb/tb_vga_pattern_engine.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pattern mode encoding and a counter-window helper.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [2:0] {
    SOLID    = 3'd0,
    BARS     = 3'd1,
    CHECKER  = 3'd2,
    GRADIENT = 3'd3,
    SCROLL   = 3'd4,
    BOX      = 3'd5
  } mode_e;

  // True when lo <= cnt < lo+len; covers both the active region and the sync pulses.
  function automatic logic in_window(input int cnt, input int lo, input int len);
    return (cnt >= lo) && (cnt < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with combinational active, sync and line/frame-end decode.
// Outputs are unregistered; the consumer adds the single pipeline stage.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          line_end,
  output logic          frame_end
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= frame_end ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  always_comb begin
    line_end  = (hcnt == HW'(H_TOTAL - 1));
    frame_end = line_end && (vcnt == VW'(V_TOTAL - 1));
    active    = in_window(int'(hcnt), 0, H_ACTIVE) && in_window(int'(vcnt), 0, V_ACTIVE);
    hsync     = in_window(int'(hcnt), H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync     = in_window(int'(vcnt), V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
  end

endmodule

// File: rtl/vga_pattern_engine.sv
// VGA test-pattern generator: six patterns, mode latched at frame end, animated scroll and bouncing box.
// One register stage from raster counters to rgb/sync/de/frame_start outputs.
module vga_pattern_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit SYNC_POL   = 1'b0,
  parameter int COLOR_BITS = 2,
  parameter int CHK_SHIFT  = 5,
  parameter int GRAD_SHIFT = 7,
  parameter int BOX_SIZE   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              mode,
  input  logic [3*COLOR_BITS-1:0] color,
  input  logic                    pause,
  output logic [COLOR_BITS-1:0]   r,
  output logic [COLOR_BITS-1:0]   g,
  output logic [COLOR_BITS-1:0]   b,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CB      = COLOR_BITS;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BPW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [HW-1:0]   hcnt;
  logic [VW-1:0]   vcnt;
  logic            active, hs_raw, vs_raw, line_end, frame_end;
  logic [2:0]      mode_r;
  logic [7:0]      frame;
  logic [HW-1:0]   bx;
  logic [VW-1:0]   by;
  logic            dx_neg, dy_neg;
  logic [BPW-1:0]  bar_pix;
  logic [2:0]      bar_idx;
  logic            scroll_on, in_box;
  logic [3*CB-1:0] pix;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .active    (active),
    .hsync     (hs_raw),
    .vsync     (vs_raw),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  // Mode, frame counter and box only move at frame end so a frame is never torn.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r <= '0;
      frame  <= '0;
      bx     <= '0;
      by     <= '0;
      dx_neg <= 1'b0;
      dy_neg <= 1'b0;
    end else if (frame_end) begin
      mode_r <= mode;
      if (!pause) begin
        frame <= frame + 8'd1;
        if (!dx_neg && bx == HW'(H_ACTIVE - BOX_SIZE)) begin
          dx_neg <= 1'b1;
          bx     <= bx - HW'(1);
        end else if (dx_neg && bx == '0) begin
          dx_neg <= 1'b0;
          bx     <= bx + HW'(1);
        end else begin
          bx <= dx_neg ? bx - HW'(1) : bx + HW'(1);
        end
        if (!dy_neg && by == VW'(V_ACTIVE - BOX_SIZE)) begin
          dy_neg <= 1'b1;
          by     <= by - VW'(1);
        end else if (dy_neg && by == '0) begin
          dy_neg <= 1'b0;
          by     <= by + VW'(1);
        end else begin
          by <= dy_neg ? by - VW'(1) : by + VW'(1);
        end
      end
    end
  end

  // Bar index tracks hcnt without a divider: it advances every BAR_W pixels.
  always_ff @(posedge clk) begin
    if (rst || line_end) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (bar_pix == BPW'(BAR_W - 1)) begin
      bar_pix <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_pix <= bar_pix + BPW'(1);
    end
  end

  always_comb begin
    scroll_on = ((10'(hcnt) + 10'(vcnt) + 10'(frame)) & 10'h010) != 10'h000;
    in_box    = (int'(hcnt) >= int'(bx)) && (int'(hcnt) < int'(bx) + BOX_SIZE) &&
                (int'(vcnt) >= int'(by)) && (int'(vcnt) < int'(by) + BOX_SIZE);
    pix       = '0;
    if (active) begin
      case (mode_r)
        SOLID:    pix = color;
        BARS:     pix = {{CB{bar_idx[2]}}, {CB{bar_idx[1]}}, {CB{bar_idx[0]}}};
        CHECKER:  pix = {(3*CB){hcnt[CHK_SHIFT] ^ vcnt[CHK_SHIFT]}};
        GRADIENT: pix = {CB'(hcnt >> GRAD_SHIFT), CB'(vcnt >> GRAD_SHIFT), {CB{1'b0}}};
        SCROLL:   pix = scroll_on ? color : '0;
        BOX:      pix = in_box ? color : ~color;
        default:  pix = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= '0;
      g           <= '0;
      b           <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      {r, g, b}   <= pix;
      hsync       <= hs_raw;
      vsync       <= vs_raw;
      de          <= active;
      frame_start <= (hcnt == '0) && (vcnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Randomized bench for vga_pattern_engine on a reduced raster, checked cycle by cycle
// against a linear-pixel-index reference model plus per-frame sync/period accounting.
module tb_vga_pattern_engine;

  localparam int HA = 32, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 16, VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int CB = 2, CS = 2, GS = 3, BS = 8;
  localparam bit POL = 1'b0;

  logic          clk = 1'b0;
  logic          rst, pause;
  logic [2:0]    mode;
  logic [5:0]    color;
  logic [CB-1:0] r, g, b;
  logic          hsync, vsync, de, frame_start;

  always #5 clk = ~clk;

  vga_pattern_engine #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .SYNC_POL (POL), .COLOR_BITS (CB), .CHK_SHIFT (CS), .GRAD_SHIFT (GS), .BOX_SIZE (BS)
  ) dut (
    .clk (clk), .rst (rst), .mode (mode), .color (color), .pause (pause),
    .r (r), .g (g), .b (b), .hsync (hsync), .vsync (vsync), .de (de),
    .frame_start (frame_start)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Reference state: position as a linear pixel index within the frame.
  int m_t, m_frame, m_mode, m_bx, m_by, m_dx, m_dy;
  // Frame-level accounting taken from DUT outputs.
  bit have_fs;
  int fs_gap, hs_cnt, vs_cnt;

  function automatic logic [9:0] model_out();
    int h, v, idx, s;
    logic act, fs, hs, vs;
    logic [5:0] px;
    h   = m_t % HT;
    v   = m_t / HT;
    act = (h < HA) && (v < VA);
    fs  = (m_t == 0);
    hs  = (h >= HA + HFP && h < HA + HFP + HS) ? POL : ~POL;
    vs  = (v >= VA + VFP && v < VA + VFP + VS) ? POL : ~POL;
    px  = 6'd0;
    if (act) begin
      case (m_mode)
        0: px = color;
        1: begin
          idx = h / (HA / 8);
          px  = {((idx & 4) != 0) ? 2'b11 : 2'b00,
                 ((idx & 2) != 0) ? 2'b11 : 2'b00,
                 ((idx & 1) != 0) ? 2'b11 : 2'b00};
        end
        2: px = ((((h >> CS) ^ (v >> CS)) & 1) != 0) ? 6'h3F : 6'h00;
        3: px = {2'((h >> GS) & 3), 2'((v >> GS) & 3), 2'b00};
        4: begin
          s  = (h + v + m_frame) % 1024;
          px = (((s >> 4) & 1) != 0) ? color : 6'h00;
        end
        5: px = (h >= m_bx && h < m_bx + BS && v >= m_by && v < m_by + BS) ? color : ~color;
        default: px = 6'h00;
      endcase
    end
    return {fs, act, hs, vs, px};
  endfunction

  task automatic model_reset();
    m_t = 0; m_frame = 0; m_mode = 0;
    m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
  endtask

  task automatic model_advance();
    if (m_t == FT - 1) begin
      m_mode = int'(mode);
      if (!pause) begin
        m_frame = (m_frame + 1) % 256;
        if (m_dx > 0 && m_bx == HA - BS) begin m_dx = -1; m_bx = m_bx - 1; end
        else if (m_dx < 0 && m_bx == 0)  begin m_dx = 1;  m_bx = m_bx + 1; end
        else m_bx = m_bx + m_dx;
        if (m_dy > 0 && m_by == VA - BS) begin m_dy = -1; m_by = m_by - 1; end
        else if (m_dy < 0 && m_by == 0)  begin m_dy = 1;  m_by = m_by + 1; end
        else m_by = m_by + m_dy;
      end
    end
    m_t = (m_t + 1) % FT;
  endtask

  // One clock: model consumes the inputs presented at this edge, DUT checked 1 time unit later.
  task automatic tick();
    logic [9:0] exp;
    logic       was_rst;
    was_rst = rst;
    @(posedge clk);
    if (was_rst) begin
      exp = {1'b0, 1'b0, ~POL, ~POL, 6'd0};
      model_reset();
    end else begin
      exp = model_out();
      model_advance();
    end
    #1;
    cycle++;
    check_eq("pixel", 32'({frame_start, de, hsync, vsync, r, g, b}), 32'(exp));
    if (was_rst) begin
      have_fs = 1'b0;
    end else begin
      if (frame_start) begin
        if (have_fs) begin
          check_eq("fs_period", 32'(fs_gap), 32'(FT));
          check_eq("hsync_per_frame", 32'(hs_cnt), 32'(HS * VT));
          check_eq("vsync_per_frame", 32'(vs_cnt), 32'(VS * HT));
        end
        have_fs = 1'b1;
        fs_gap = 0; hs_cnt = 0; vs_cnt = 0;
      end
      fs_gap++;
      if (hsync == POL) hs_cnt++;
      if (vsync == POL) vs_cnt++;
    end
  endtask

  initial begin
    have_fs = 1'b0;
    fs_gap = 0; hs_cnt = 0; vs_cnt = 0;
    model_reset();
    rst = 1'b1; mode = 3'd0; color = 6'h2D; pause = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Colour bars, latched at the first frame end.
    mode = 3'd1;
    repeat (2 * FT) tick();

    // Mid-frame mode change must wait for the next frame.
    mode = 3'd0;
    repeat (FT) tick();
    while (m_t != 5 * HT) tick();
    mode = 3'd2;
    repeat (2 * FT) tick();

    // Random modes, colours and pauses with changes landing anywhere in the frame.
    repeat (8 * FT) begin
      if ($urandom_range(0, 299) == 0) mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0)  color = 6'($urandom);
      pause = ($urandom_range(0, 3) == 0);
      tick();
    end

    // Bouncing box long enough to hit both a reversal in x and in y.
    mode = 3'd5; pause = 1'b0; color = 6'($urandom);
    repeat (28 * FT) begin
      if ($urandom_range(0, 999) == 0) color = 6'($urandom);
      tick();
    end
    pause = 1'b1;
    repeat (2 * FT) tick();

    // Scroll, then a one-cycle reset in the middle of a frame.
    pause = 1'b0; mode = 3'd4;
    repeat (FT + $urandom_range(100, 700)) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3 * FT + 5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
